aib_adapt_cmn_pulse_shrink: RTL



---
 rtl/aib_adapt_cmn_pulse_shrink_if.sv | 23 ++
 rtl/aib_adapt_cmn_pulse_shrink.sv | 113 +++++++++++
 2 files changed

// File: rtl/aib_adapt_cmn_pulse_shrink_if.sv
// Event/status bundle between a pulse-shrink block and its consumer.
// master drives qualification inputs; slave is the shrinker itself.
interface aib_adapt_cmn_pulse_shrink_if #(
  parameter int CNT_WIDTH = 8
);
  logic [2:0]           min_width;
  logic                 data_in;
  logic                 err_clr;
  logic                 pulse_out;
  logic [CNT_WIDTH-1:0] evt_cnt;
  logic                 err_short;
  logic                 err_stuck;

  modport master (
    output min_width, data_in, err_clr,
    input  pulse_out, evt_cnt, err_short, err_stuck
  );

  modport slave (
    input  min_width, data_in, err_clr,
    output pulse_out, evt_cnt, err_short, err_stuck
  );
endinterface

// File: rtl/aib_adapt_cmn_pulse_shrink.sv
// Turns a stretched, synchronised level back into one-cycle events, qualifying
// each high run against min_width+1 and flagging short or stuck runs.
module aib_adapt_cmn_pulse_shrink #(
  parameter int MAX_HIGH  = 16,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  aib_adapt_cmn_pulse_shrink_if.slave bus
);
  localparam int RUN_W = $clog2(MAX_HIGH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_HIGH);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_HIGH - 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    QUAL     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t               state_r;
  logic [RUN_W-1:0]     run_r;
  logic                 pulse_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 err_short_r;
  logic                 err_stuck_r;
  logic [RUN_W-1:0]     run_inc_s;
  logic [RUN_W-1:0]     qual_len_s;

  // Saturating run increment and the current qualify length.
  always_comb begin
    qual_len_s = RUN_W'(bus.min_width) + RUN_W'(1);
    if (run_r == RUN_MAX) begin
      run_inc_s = run_r;
    end else begin
      run_inc_s = run_r + RUN_W'(1);
    end
  end

  // Qualification FSM with registered strobe, event counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_LOW;
      run_r       <= '0;
      pulse_r     <= 1'b0;
      cnt_r       <= '0;
      err_short_r <= 1'b0;
      err_stuck_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      // Clear first so a set condition later in this block wins.
      if (bus.err_clr) begin
        err_short_r <= 1'b0;
        err_stuck_r <= 1'b0;
      end
      case (state_r)
        WAIT_LOW: begin
          run_r <= '0;
          if (!bus.data_in) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (bus.data_in) begin
            run_r <= RUN_W'(1);
            if (bus.min_width == 3'd0) begin
              state_r <= HOLD;
              pulse_r <= 1'b1;
              cnt_r   <= cnt_r + CNT_WIDTH'(1);
            end else begin
              state_r <= QUAL;
            end
          end
        end
        QUAL: begin
          if (bus.data_in) begin
            run_r <= run_inc_s;
            if (run_inc_s >= qual_len_s) begin
              state_r <= HOLD;
              pulse_r <= 1'b1;
              cnt_r   <= cnt_r + CNT_WIDTH'(1);
            end
          end else begin
            err_short_r <= 1'b1;
            run_r       <= '0;
            state_r     <= IDLE;
          end
        end
        HOLD: begin
          if (bus.data_in) begin
            run_r <= run_inc_s;
            if (run_r == RUN_LAST) begin
              err_stuck_r <= 1'b1;
            end
          end else begin
            run_r   <= '0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= WAIT_LOW;
          run_r   <= '0;
        end
      endcase
    end
  end

  assign bus.pulse_out = pulse_r;
  assign bus.evt_cnt   = cnt_r;
  assign bus.err_short = err_short_r;
  assign bus.err_stuck = err_stuck_r;
endmodule
